qracc_mac_seq: RTL and testbench
================================

# qracc_mac_seq

Bit-serial MAC sequencer driving the MAC-side interface of `qr_acc_wrapper`. It accepts one vector of signed multi-bit activations and issues it to the array one bit-plane per cycle as bipolar `data_p`/`data_n` row selects with `mac_en` asserted. It then shift-accumulates the wrapper's registered signed ADC codes per column into a multi-bit result. The block sits between the activation buffer and the wrapper, and its result feeds the output/requantisation stage.

## Interface
Parameters:
- `numRows`, 128, array rows (activation vector length).
- `numCols`, 32, array columns (result vector length).
- `numAdcBits`, 4, width of the signed ADC code per column.
- `actBits`, 4, signed two's-complement activation width; must be ≥ 2.
- `accBits`, 16, signed accumulator width; elaboration-time assertion `accBits >= numAdcBits + actBits`.

Ports:
- `clk` in 1: single clock.
- `nrst` in 1: asynchronous, active-low reset.
- `act_i` in `[numRows][actBits]`: activation vector, signed.
- `act_valid_i` in 1: activation vector valid.
- `act_ready_o` out 1: block accepts a vector.
- `mac_en_o` out 1: to wrapper `mac_en_i`.
- `data_p_o` out `numRows`: to wrapper `data_p_i`.
- `data_n_o` out `numRows`: to wrapper `data_n_i`.
- `adc_in_i` in `[numCols][numAdcBits]`: from wrapper `adc_out_o`, signed.
- `result_o` out `[numCols][accBits]`: signed accumulated MAC result.
- `result_valid_o` out 1: result valid.
- `result_ready_i` in 1: consumer takes the result.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, COMPUTE, DRAIN, DONE.
- IDLE:
  - `act_ready_o`=1.
  - When `act_valid_i & act_ready_o`, latch `act_i`, clear all accumulators, set plane counter `b`=0, and go to COMPUTE.
- COMPUTE lasts `actBits` cycles; in cycle `b`:
  - Drive `mac_en_o`=1.
  - For `b < actBits-1`: `data_p_o[r]`=`act[r][b]`, `data_n_o`=0.
  - For `b == actBits-1` (MSB, weight −2^(actBits−1)): `data_n_o[r]`=`act[r][b]`, `data_p_o`=0.
  - `data_p_o & data_n_o` is always 0.
  - Increment `b`; after the last plane, go to DRAIN.
- Accumulation happens one cycle behind issue. In the cycle after plane `b` is issued (COMPUTE cycles 1..actBits−1, and DRAIN for the last plane):
  - `acc[c] += sext(adc_in_i[c]) <<< b`.
  - This is uniform for all planes, because the MSB plane's negation is realised by driving `data_n`.
- DRAIN: `mac_en_o`=0, data outputs 0, accumulate the last plane, then go to DONE.
- DONE:
  - `result_valid_o`=1 and `result_o`=`acc`, held stable until `result_ready_i`=1.
  - On that cycle, go to IDLE.
  - `act_ready_o`=0.
- Arithmetic: sign-extend the ADC code to `accBits` before shifting. No overflow is possible under the width assertion, so no saturation logic.
- All-zero activations still run all planes; the rows see reset (`p`=`n`=0) and results reflect the ADC output.
- Outside COMPUTE: `mac_en_o`=0 and `data_p_o`=`data_n_o`=0.

## Timing
- Reset values:
  - state IDLE, `act_ready_o`=1, `busy_o`=0, `mac_en_o`=0.
  - `data_p_o`=0, `data_n_o`=0.
  - `result_o`=0, `result_valid_o`=0.
  - accumulators and latched activations 0.
- All outputs are registered except `act_ready_o`/`busy_o`, which decode directly from state.
- Accept edge E0: plane `b` is driven in cycle `b` after E0, and its ADC code is sampled in cycle `b+1`.
- `result_valid_o` rises `actBits+1` cycles after E0.
- Period is `actBits+3` cycles per vector with `result_ready_i` tied high.
- `nrst` low at any point: all state returns to reset values immediately (asynchronous). Any in-flight vector is discarded, with no partial result.
- `act_valid_i` outside IDLE is ignored (not captured).
- `act_i` may change after acceptance.

## Structure
- `qracc_pkg` additions: `typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} mac_seq_state_t`.
- Plane counter width: `$clog2(actBits)`, local.
- Sub-module: `qracc_shift_acc`, one signed accumulator (clear, enable, shift amount, `numAdcBits` in, `accBits` out), instantiated `numCols` times in a generate loop.

## Test plan
- All activations = 1, ADC stub returns +3 only for the plane-0 sample and 0 otherwise -> `result_o[c]`=3 for all `c`; `data_p_o` all-ones only in COMPUTE cycle 0.
- actBits=4, ADC stub constant +1 every sample -> `result_o[c]`=1+2+4+8=15; `result_valid_o` rises 5 cycles after accept.
- ADC stub −8 for the MSB sample only -> `result_o`=−64. Also check that in the MSB cycle `data_n_o` equals act bit 3 and `data_p_o`=0.
- `result_ready_i` low for 5 cycles in DONE -> `result_o`/`result_valid_o` stable, `act_ready_o`=0, new `act_valid_i` not captured; release -> IDLE next cycle.
- `nrst` pulsed in COMPUTE plane 2 -> `mac_en_o`, `data_*`=0 immediately, `act_ready_o`=1, next vector produces a correct, uncontaminated result.
- Back-to-back: `act_valid_i` and `result_ready_i` held high for 10 vectors -> one result per 7 cycles (actBits=4); every cycle checks `data_p_o & data_n_o`==0.

Source files
------------

// File: rtl/qracc_pkg.sv
// Shared types for the QR accelerator datapath blocks.
package qracc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DRAIN,
        DONE
    } mac_seq_state_t;

endpackage

// File: rtl/qracc_shift_acc.sv
// One signed shift-accumulator: acc += sext(adc) <<< shift, with synchronous clear.
module qracc_shift_acc #(
    parameter int numAdcBits = 4,
    parameter int accBits    = 16,
    parameter int shBits     = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [shBits-1:0]     shift_i,
    input  logic [numAdcBits-1:0] adc_i,
    output logic [accBits-1:0]    acc_o
);

    logic signed [accBits-1:0] acc_q, acc_d;
    logic signed [accBits-1:0] adc_ext;

    // Sign-extend before shifting so negative codes keep their weight.
    assign adc_ext = {{(accBits-numAdcBits){adc_i[numAdcBits-1]}}, adc_i};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + (adc_ext <<< shift_i);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/qracc_mac_seq.sv
// Bit-serial MAC sequencer: issues activation bit-planes as bipolar row selects
// and shift-accumulates the wrapper's per-column ADC codes into a signed result.
module qracc_mac_seq
    import qracc_pkg::*;
#(
    parameter int numRows    = 128,
    parameter int numCols    = 32,
    parameter int numAdcBits = 4,
    parameter int actBits    = 4,
    parameter int accBits    = 16
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic [numRows-1:0][actBits-1:0]    act_i,
    input  logic                               act_valid_i,
    output logic                               act_ready_o,
    output logic                               mac_en_o,
    output logic [numRows-1:0]                 data_p_o,
    output logic [numRows-1:0]                 data_n_o,
    input  logic [numCols-1:0][numAdcBits-1:0] adc_in_i,
    output logic [numCols-1:0][accBits-1:0]    result_o,
    output logic                               result_valid_o,
    input  logic                               result_ready_i,
    output logic                               busy_o
);

    localparam int bW = (actBits > 1) ? $clog2(actBits) : 1;
    localparam logic [bW-1:0] LastPlane = bW'(actBits - 1);

    if (actBits < 2) begin : g_bad_act
        $error("qracc_mac_seq: actBits must be >= 2");
    end
    if (accBits < numAdcBits + actBits) begin : g_bad_acc
        $error("qracc_mac_seq: accBits must be >= numAdcBits + actBits");
    end

    mac_seq_state_t                 state_q, state_d;
    logic [bW-1:0]                  b_q, b_d;
    logic [numRows-1:0][actBits-1:0] act_q, act_d;
    logic                           mac_en_q, mac_en_d;
    logic [numRows-1:0]             data_p_q, data_p_d;
    logic [numRows-1:0]             data_n_q, data_n_d;
    logic                           result_valid_q, result_valid_d;
    logic                           acc_clr;
    logic                           acc_en;
    logic [bW-1:0]                  acc_sh;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        b_d     = b_q;
        act_d   = act_q;
        acc_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (act_valid_i) begin
                    state_d = COMPUTE;
                    b_d     = '0;
                    act_d   = act_i;
                    acc_clr = 1'b1;
                end
            end
            COMPUTE: begin
                if (b_q == LastPlane) begin
                    state_d = DRAIN;
                    b_d     = '0;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    if (result_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next state, so plane b appears in cycle b after accept.
    always_comb begin
        mac_en_d       = (state_d == COMPUTE);
        result_valid_d = (state_d == DONE);
        data_p_d       = '0;
        data_n_d       = '0;
        if (mac_en_d) begin
            for (int r = 0; r < numRows; r++) begin
                if (b_d == LastPlane) begin
                    data_n_d[r] = act_d[r][b_d];
                end else begin
                    data_p_d[r] = act_d[r][b_d];
                end
            end
        end
    end

    // The ADC code for plane b arrives one cycle after it is issued.
    assign acc_en = ((state_q == COMPUTE) && (b_q != '0)) || (state_q == DRAIN);
    assign acc_sh = (state_q == DRAIN) ? LastPlane : (b_q - 1'b1);

    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!nrst) begin
            // NOTE: the activation latch is reset too, so nothing from a discarded vector survives.
            state_q        <= IDLE;
            b_q            <= '0;
            act_q          <= '0;
            mac_en_q       <= 1'b0;
            data_p_q       <= '0;
            data_n_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            b_q            <= b_d;
            act_q          <= act_d;
            mac_en_q       <= mac_en_d;
            data_p_q       <= data_p_d;
            data_n_q       <= data_n_d;
            result_valid_q <= result_valid_d;
        end
    end

    for (genvar c = 0; c < numCols; c++) begin : g_col
        qracc_shift_acc #(
            .numAdcBits (numAdcBits),
            .accBits    (accBits),
            .shBits     (bW)
        ) u_acc (
            .clk     (clk),
            .nrst    (nrst),
            .clr_i   (acc_clr),
            .en_i    (acc_en),
            .shift_i (acc_sh),
            .adc_i   (adc_in_i[c]),
            .acc_o   (result_o[c])
        );
    end

    assign act_ready_o    = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign mac_en_o       = mac_en_q;
    assign data_p_o       = data_p_q;
    assign data_n_o       = data_n_q;
    assign result_valid_o = result_valid_q;

endmodule

// File: tb/tb_qracc_mac_seq.sv
// Scoreboard bench for qracc_mac_seq with a registered wrapper stub (plane table or small array model).
module tb_qracc_mac_seq;

    localparam int NR  = 128;
    localparam int NC  = 32;
    localparam int AB  = 4;
    localparam int ACT = 4;
    localparam int ACC = 16;
    localparam int W   = NC * ACC;

    typedef logic [NR-1:0][ACT-1:0] act_t;
    typedef logic [NC-1:0][ACC-1:0] res_t;

    logic                      clk;
    logic                      nrst;
    act_t                      act_i;
    logic                      act_valid_i;
    logic                      act_ready_o;
    logic                      mac_en_o;
    logic [NR-1:0]             data_p_o;
    logic [NR-1:0]             data_n_o;
    logic [NC-1:0][AB-1:0]     adc_in_i;
    res_t                      result_o;
    logic                      result_valid_o;
    logic                      result_ready_i;
    logic                      busy_o;

    qracc_mac_seq #(
        .numRows    (NR),
        .numCols    (NC),
        .numAdcBits (AB),
        .actBits    (ACT),
        .accBits    (ACC)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .act_i          (act_i),
        .act_valid_i    (act_valid_i),
        .act_ready_o    (act_ready_o),
        .mac_en_o       (mac_en_o),
        .data_p_o       (data_p_o),
        .data_n_o       (data_n_o),
        .adc_in_i       (adc_in_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Wrapper stub: mode 0 returns tab[plane] on every column, mode 1 a tiny ternary-weight array.
    int                  mode = 0;
    logic signed [AB-1:0] tab [ACT];
    int                  pcnt = 0;

    function automatic logic signed [AB-1:0] arr_code(int c, logic [NR-1:0] p, logic [NR-1:0] n);
        int s;
        s = 0;
        for (int r = 0; r < 8; r++) begin
            int w;
            w = ((r + c) % 3) - 1;
            s += w * (int'(p[r]) - int'(n[r]));
        end
        if (s > 7)  s = 7;
        if (s < -8) s = -8;
        return AB'(s);
    endfunction

    always @(posedge clk) begin
        if (mac_en_o) begin
            for (int c = 0; c < NC; c++) begin
                adc_in_i[c] <= (mode == 0) ? tab[pcnt % ACT] : arr_code(c, data_p_o, data_n_o);
            end
            pcnt <= pcnt + 1;
        end else begin
            adc_in_i <= '0;
            pcnt     <= 0;
        end
    end

    // Expected result from the stimulus alone: each plane's code weighted by +2^b.
    function automatic res_t model(act_t a);
        res_t e;
        logic [NR-1:0] p, n;
        for (int c = 0; c < NC; c++) begin
            int acc;
            acc = 0;
            for (int b = 0; b < ACT; b++) begin
                logic signed [AB-1:0] code;
                for (int r = 0; r < NR; r++) begin
                    p[r] = (b < ACT-1) ? a[r][b] : 1'b0;
                    n[r] = (b == ACT-1) ? a[r][b] : 1'b0;
                end
                code = (mode == 0) ? tab[b] : arr_code(c, p, n);
                acc += int'(code) * (1 << b);
            end
            e[c] = ACC'(acc);
        end
        return e;
    endfunction

    task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    res_t q[$];
    act_t exp_act;
    int   cyc        = 0;
    int   acc_cyc    = 0;
    int   last_push  = -1;
    bit   inflight   = 0;
    bit   b2b        = 0;
    logic prev_valid = 1'b0;

    // Inputs are set by the caller at a negedge; handshakes are evaluated before the next posedge.
    task automatic cycle();
        logic          em;
        logic [NR-1:0] ep, en;
        if (act_valid_i && act_ready_o) begin
            if (b2b && last_push >= 0) check("period", cyc - last_push, ACT + 3);
            last_push = cyc;
            q.push_back(model(act_i));
            exp_act  = act_i;
            acc_cyc  = cyc;
            inflight = 1;
        end
        if (result_valid_o && result_ready_i) begin
            if (q.size() == 0) check("spurious_result", 1, 0);
            else               check("result", result_o, q.pop_front());
        end
        @(negedge clk);
        cyc++;
        em = 1'b0;
        ep = '0;
        en = '0;
        if (inflight) begin
            int k;
            k = cyc - acc_cyc - 1;
            if (k >= ACT) begin
                inflight = 0;
            end else begin
                em = 1'b1;
                for (int r = 0; r < NR; r++) begin
                    if (k == ACT-1) en[r] = exp_act[r][k];
                    else            ep[r] = exp_act[r][k];
                end
            end
        end
        check("p_and_n", data_p_o & data_n_o, 0);
        check("mac_en", mac_en_o, em);
        check("data_p", data_p_o, ep);
        check("data_n", data_n_o, en);
        if (result_valid_o && !prev_valid) check("latency", cyc - acc_cyc, ACT + 2);
        prev_valid = result_valid_o;
    endtask

    function automatic act_t rnd_act();
        act_t a;
        for (int r = 0; r < NR; r++) a[r] = ACT'($urandom);
        return a;
    endfunction

    task automatic send(act_t a);
        bit done;
        done        = 0;
        act_i       = a;
        act_valid_i = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            done = act_ready_o;
            cycle();
        end
        act_valid_i = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
        check("drain", q.size(), 0);
    endtask

    task automatic set_tab(int t0, int t1, int t2, int t3);
        tab[0] = AB'(t0);
        tab[1] = AB'(t1);
        tab[2] = AB'(t2);
        tab[3] = AB'(t3);
    endtask

    initial begin
        act_t a;
        res_t r0;
        int   nacc;

        nrst           = 1'b0;
        act_i          = '0;
        act_valid_i    = 1'b0;
        result_ready_i = 1'b1;
        set_tab(0, 0, 0, 0);
        @(negedge clk);
        check("rst_act_ready", act_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_mac_en", mac_en_o, 0);
        check("rst_data_p", data_p_o, 0);
        check("rst_data_n", data_n_o, 0);
        check("rst_result", result_o, 0);
        check("rst_valid", result_valid_o, 0);
        @(negedge clk);
        nrst = 1'b1;
        cycle();

        // Plane-0-only code with all activations = 1.
        mode = 0;
        set_tab(3, 0, 0, 0);
        for (int r = 0; r < NR; r++) a[r] = ACT'(1);
        send(a);
        drain();

        // Constant +1 per plane: 1+2+4+8.
        set_tab(1, 1, 1, 1);
        send(rnd_act());
        drain();

        // -8 on the MSB sample only: -64.
        set_tab(0, 0, 0, -8);
        send(rnd_act());
        drain();

        // Array-model stimulus, including a couple of corner vectors.
        mode = 1;
        for (int r = 0; r < NR; r++) a[r] = ACT'(8);
        send(a);
        drain();
        send('0);
        drain();
        for (int i = 0; i < 3; i++) begin
            send(rnd_act());
            drain();
        end

        // Consumer stalls for five cycles in DONE; new vectors must be ignored.
        result_ready_i = 1'b0;
        send(rnd_act());
        for (int i = 0; i < 20 && !result_valid_o; i++) cycle();
        check("stall_valid_rise", result_valid_o, 1);
        r0 = result_o;
        for (int i = 0; i < 5; i++) begin
            act_i       = rnd_act();
            act_valid_i = 1'b1;
            cycle();
            check("stall_result", result_o, r0);
            check("stall_valid", result_valid_o, 1);
            check("stall_ready", act_ready_o, 0);
            check("stall_busy", busy_o, 1);
        end
        act_valid_i    = 1'b0;
        result_ready_i = 1'b1;
        cycle();
        check("release_ready", act_ready_o, 1);
        check("release_valid", result_valid_o, 0);
        check("release_busy", busy_o, 0);
        check("release_q", q.size(), 0);

        // Asynchronous reset during plane 2.
        send(rnd_act());
        cycle();
        cycle();
        nrst = 1'b0;
        #1;
        check("arst_mac_en", mac_en_o, 0);
        check("arst_data_p", data_p_o, 0);
        check("arst_data_n", data_n_o, 0);
        check("arst_ready", act_ready_o, 1);
        check("arst_busy", busy_o, 0);
        check("arst_result", result_o, 0);
        q.delete();
        inflight = 0;
        #1;
        nrst = 1'b1;
        cycle();
        send(rnd_act());
        drain();

        // Back-to-back vectors with valid and ready held high.
        b2b         = 1;
        last_push   = -1;
        nacc        = 0;
        act_i       = rnd_act();
        act_valid_i = 1'b1;
        for (int i = 0; i < 200 && nacc < 10; i++) begin
            bit took;
            took = act_valid_i && act_ready_o;
            cycle();
            if (took) begin
                nacc++;
                act_i = rnd_act();
            end
        end
        act_valid_i = 1'b0;
        b2b         = 0;
        check("b2b_count", nacc, 10);
        drain();

        check("q_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
